// File: rtl/ahb_arb_pkg.sv
// Shared encodings and payload types for the two-master AHB BRAM arbiter.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_M0   = 2'd1,
      OWNER_M1   = 2'd2
   } owner_t;

   // Address-phase fields that must survive a stall or a lost arbitration.
   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  prot;
      logic        write;
   } req_t;

endpackage

// File: rtl/ahb_req_hold.sv
// One master port's parked address phase: captured when the live request
// cannot go to the slave this cycle, released when it is finally issued.
module ahb_req_hold
   import ahb_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic cap,
   input  logic clr,
   input  req_t req,
   output logic valid,
   output req_t held
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         held  <= '0;
      end else if (cap) begin
         valid <= 1'b1;
         held  <= req;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ahb_bram_arbiter.sv
// Two-master to one-BRAM-slave AHB arbiter: held requests beat live ones,
// ties alternate, and a saturating counter records same-cycle contention.
module ahb_bram_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 M0_HSEL,
   input  logic [1:0]           M0_HTRANS,
   input  logic                 M0_HWRITE,
   input  logic [31:0]          M0_HADDR,
   input  logic [2:0]           M0_HSIZE,
   input  logic [3:0]           M0_HPROT,
   input  logic [31:0]          M0_HWDATA,
   input  logic                 M0_HREADY,
   output logic                 M0_HREADYOUT,
   output logic [31:0]          M0_HRDATA,
   output logic                 M0_HRESP,
   input  logic                 M1_HSEL,
   input  logic [1:0]           M1_HTRANS,
   input  logic                 M1_HWRITE,
   input  logic [31:0]          M1_HADDR,
   input  logic [2:0]           M1_HSIZE,
   input  logic [3:0]           M1_HPROT,
   input  logic [31:0]          M1_HWDATA,
   input  logic                 M1_HREADY,
   output logic                 M1_HREADYOUT,
   output logic [31:0]          M1_HRDATA,
   output logic                 M1_HRESP,
   output logic                 S_HSEL,
   output logic [1:0]           S_HTRANS,
   output logic                 S_HWRITE,
   output logic [31:0]          S_HADDR,
   output logic [2:0]           S_HSIZE,
   output logic [3:0]           S_HPROT,
   output logic [31:0]          S_HWDATA,
   input  logic                 S_HREADYOUT,
   input  logic [31:0]          S_HRDATA,
   input  logic                 S_HRESP,
   output logic                 S_HREADY,
   output logic [CNT_WIDTH-1:0] CONFLICT_CNT
);

   logic   live0, live1, cand0, cand1, hv0, hv1;
   logic   pick0, win0, win1, cap0, cap1, conflict;
   logic   last_grant;
   req_t   live_req0, live_req1, held0, held1, req0, req1, s_req;
   owner_t owner;
   logic   unused_htrans;

   assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

   assign live0 = M0_HSEL & M0_HTRANS[1] & M0_HREADY;
   assign live1 = M1_HSEL & M1_HTRANS[1] & M1_HREADY;
   assign live_req0 = '{addr: M0_HADDR, size: M0_HSIZE, prot: M0_HPROT, write: M0_HWRITE};
   assign live_req1 = '{addr: M1_HADDR, size: M1_HSIZE, prot: M1_HPROT, write: M1_HWRITE};

   assign cand0 = hv0 | live0;
   assign cand1 = hv1 | live1;
   assign req0  = hv0 ? held0 : live_req0;
   assign req1  = hv1 ? held1 : live_req1;

   // Held beats live; equal classes go to whoever was not granted last.
   assign pick0    = (hv0 != hv1) ? hv0 : last_grant;
   assign win0     = S_HREADYOUT & cand0 & (~cand1 | pick0);
   assign win1     = S_HREADYOUT & cand1 & (~cand0 | ~pick0);
   assign conflict = S_HREADYOUT & cand0 & cand1;

   assign cap0 = live0 & ~hv0 & ~win0;
   assign cap1 = live1 & ~hv1 & ~win1;

   ahb_req_hold u_hold0 (
      .clk   (HCLK),
      .rst   (HRESET),
      .cap   (cap0),
      .clr   (win0),
      .req   (live_req0),
      .valid (hv0),
      .held  (held0)
   );

   ahb_req_hold u_hold1 (
      .clk   (HCLK),
      .rst   (HRESET),
      .cap   (cap1),
      .clr   (win1),
      .req   (live_req1),
      .valid (hv1),
      .held  (held1)
   );

   always_comb begin
      S_HSEL   = 1'b0;
      S_HTRANS = HTRANS_IDLE;
      s_req    = '0;
      if (win0) begin
         S_HSEL   = 1'b1;
         S_HTRANS = HTRANS_NONSEQ;
         s_req    = req0;
      end else if (win1) begin
         S_HSEL   = 1'b1;
         S_HTRANS = HTRANS_NONSEQ;
         s_req    = req1;
      end
   end

   assign S_HADDR  = s_req.addr;
   assign S_HSIZE  = s_req.size;
   assign S_HPROT  = s_req.prot;
   assign S_HWRITE = s_req.write;
   assign S_HREADY = S_HREADYOUT;

   // Data-phase owner, grant history and contention counter.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         owner        <= OWNER_NONE;
         last_grant   <= 1'b1;
         CONFLICT_CNT <= '0;
      end else begin
         if (S_HREADYOUT) begin
            if (win0)      owner <= OWNER_M0;
            else if (win1) owner <= OWNER_M1;
            else           owner <= OWNER_NONE;
         end
         if (win0 | win1)
            last_grant <= win1;
         if (conflict && !(&CONFLICT_CNT))
            CONFLICT_CNT <= CONFLICT_CNT + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      S_HWDATA     = 32'h0;
      M0_HREADYOUT = 1'b1;
      M1_HREADYOUT = 1'b1;
      M0_HRESP     = 1'b0;
      M1_HRESP     = 1'b0;
      if (owner == OWNER_M0) begin
         S_HWDATA     = M0_HWDATA;
         M0_HREADYOUT = S_HREADYOUT;
         M0_HRESP     = S_HRESP;
      end else if (owner == OWNER_M1) begin
         S_HWDATA     = M1_HWDATA;
         M1_HREADYOUT = S_HREADYOUT;
         M1_HRESP     = S_HRESP;
      end
      if (hv0) M0_HREADYOUT = 1'b0;
      if (hv1) M1_HREADYOUT = 1'b0;
   end

   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahb_bram_arbiter.sv
// Directed bench for ahb_bram_arbiter: single master, ties, stalls, reset
// and counter saturation, each step checked against hand-derived values.
module tb_ahb_bram_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        M0_HSEL, M0_HWRITE, M0_HREADY, M0_HREADYOUT, M0_HRESP;
   logic [1:0]  M0_HTRANS;
   logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
   logic [2:0]  M0_HSIZE;
   logic [3:0]  M0_HPROT;
   logic        M1_HSEL, M1_HWRITE, M1_HREADY, M1_HREADYOUT, M1_HRESP;
   logic [1:0]  M1_HTRANS;
   logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
   logic [2:0]  M1_HSIZE;
   logic [3:0]  M1_HPROT;
   logic        S_HSEL, S_HWRITE, S_HREADYOUT, S_HRESP, S_HREADY;
   logic [1:0]  S_HTRANS;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   logic [2:0]  S_HSIZE;
   logic [3:0]  S_HPROT;
   logic [15:0] CONFLICT_CNT;
   logic        force_rdy;
   int          checks = 0;
   int          errors = 0;

   always #5 HCLK = ~HCLK;

   // Single-slave bus: each master's HREADY is the arbiter's own HREADYOUT.
   assign M0_HREADY = force_rdy | M0_HREADYOUT;
   assign M1_HREADY = force_rdy | M1_HREADYOUT;

   ahb_bram_arbiter #(.CNT_WIDTH(16)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .M0_HSEL(M0_HSEL), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
      .M0_HADDR(M0_HADDR), .M0_HSIZE(M0_HSIZE), .M0_HPROT(M0_HPROT),
      .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
      .M0_HREADYOUT(M0_HREADYOUT), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
      .M1_HSEL(M1_HSEL), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
      .M1_HADDR(M1_HADDR), .M1_HSIZE(M1_HSIZE), .M1_HPROT(M1_HPROT),
      .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
      .M1_HREADYOUT(M1_HREADYOUT), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
      .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
      .S_HADDR(S_HADDR), .S_HSIZE(S_HSIZE), .S_HPROT(S_HPROT),
      .S_HWDATA(S_HWDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA),
      .S_HRESP(S_HRESP), .S_HREADY(S_HREADY), .CONFLICT_CNT(CONFLICT_CNT)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic smp();
      @(negedge HCLK);
   endtask

   task automatic m0(input logic req, input logic wr, input logic [31:0] addr);
      M0_HSEL = req; M0_HTRANS = req ? 2'b10 : 2'b00; M0_HWRITE = wr; M0_HADDR = addr;
   endtask

   task automatic m1(input logic req, input logic wr, input logic [31:0] addr);
      M1_HSEL = req; M1_HTRANS = req ? 2'b10 : 2'b00; M1_HWRITE = wr; M1_HADDR = addr;
   endtask

   initial begin
      HRESET = 1'b1; force_rdy = 1'b0;
      m0(1'b0, 1'b0, 32'h0); m1(1'b0, 1'b0, 32'h0);
      M0_HSIZE = 3'd2; M0_HPROT = 4'h3; M0_HWDATA = 32'h0;
      M1_HSIZE = 3'd2; M1_HPROT = 4'h3; M1_HWDATA = 32'h0;
      S_HREADYOUT = 1'b1; S_HRDATA = 32'h0; S_HRESP = 1'b0;
      cyc(); cyc();
      HRESET = 1'b0;
      smp();
      check("rst_m0_ready", 32'(M0_HREADYOUT), 32'd1);
      check("rst_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      check("rst_s_hsel",   32'(S_HSEL), 32'd0);
      check("rst_s_htrans", 32'(S_HTRANS), 32'd0);
      check("rst_cnt",      32'(CONFLICT_CNT), 32'd0);
      cyc();

      // M0 write alone: same-cycle issue, write data next cycle.
      m0(1'b1, 1'b1, 32'h0000_0010);
      smp();
      check("solo_s_hsel",   32'(S_HSEL), 32'd1);
      check("solo_s_htrans", 32'(S_HTRANS), 32'd2);
      check("solo_s_haddr",  S_HADDR, 32'h10);
      check("solo_s_hwrite", 32'(S_HWRITE), 32'd1);
      check("solo_m0_ready", 32'(M0_HREADYOUT), 32'd1);
      check("solo_s_hready", 32'(S_HREADY), 32'd1);
      cyc();
      m0(1'b0, 1'b0, 32'h0); M0_HWDATA = 32'hDEAD_BEEF;
      smp();
      check("solo_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);
      check("solo_idle_hsel", 32'(S_HSEL), 32'd0);
      check("solo_cnt", 32'(CONFLICT_CNT), 32'd0);
      cyc();

      // Back-to-back simultaneous requests, last grant M0: M1, M0, M1.
      m0(1'b1, 1'b0, 32'h100); m1(1'b1, 1'b0, 32'h200);
      smp();
      check("alt1_haddr", S_HADDR, 32'h200);
      check("alt1_hsel", 32'(S_HSEL), 32'd1);
      cyc();
      m1(1'b1, 1'b0, 32'h204);
      smp();
      check("alt2_m0_ready", 32'(M0_HREADYOUT), 32'd0);
      check("alt2_haddr", S_HADDR, 32'h100);
      cyc();
      m0(1'b1, 1'b0, 32'h104);
      smp();
      check("alt3_m1_ready", 32'(M1_HREADYOUT), 32'd0);
      check("alt3_haddr", S_HADDR, 32'h204);
      cyc();
      m0(1'b0, 1'b0, 32'h0); m1(1'b0, 1'b0, 32'h0);
      smp();
      check("alt4_haddr", S_HADDR, 32'h104);
      check("alt4_cnt", 32'(CONFLICT_CNT), 32'd3);
      cyc();
      smp();
      check("alt5_hsel", 32'(S_HSEL), 32'd0);
      check("alt5_cnt", 32'(CONFLICT_CNT), 32'd3);
      cyc();

      HRESET = 1'b1;
      cyc();
      HRESET = 1'b0;
      smp();
      check("rst2_cnt", 32'(CONFLICT_CNT), 32'd0);
      cyc();

      // Tie after reset: M0 first, M1 parked and issued next cycle.
      m0(1'b1, 1'b0, 32'h20); m1(1'b1, 1'b0, 32'h40);
      smp();
      check("tie_haddr", S_HADDR, 32'h20);
      check("tie_hwrite", 32'(S_HWRITE), 32'd0);
      check("tie_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      cyc();
      m0(1'b0, 1'b0, 32'h0); m1(1'b0, 1'b0, 32'h0);
      S_HRDATA = 32'h1234_5678; S_HRESP = 1'b1;
      smp();
      check("held_m1_ready", 32'(M1_HREADYOUT), 32'd0);
      check("held_hsel", 32'(S_HSEL), 32'd1);
      check("held_haddr", S_HADDR, 32'h40);
      check("m0_hrdata", M0_HRDATA, 32'h1234_5678);
      check("m1_hrdata", M1_HRDATA, 32'h1234_5678);
      check("m0_hresp_owner", 32'(M0_HRESP), 32'd1);
      check("m1_hresp_other", 32'(M1_HRESP), 32'd0);
      cyc();
      S_HRESP = 1'b0;
      smp();
      check("tie_done_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      check("tie_done_hsel", 32'(S_HSEL), 32'd0);
      check("tie_cnt", 32'(CONFLICT_CNT), 32'd1);
      cyc();

      // Slave stall during M0 data phase while M1 requests.
      m0(1'b1, 1'b1, 32'h80); M0_HWDATA = 32'hA5A5_0001;
      smp();
      check("stall_issue_haddr", S_HADDR, 32'h80);
      cyc();
      m0(1'b0, 1'b0, 32'h0); m1(1'b1, 1'b0, 32'hC0); S_HREADYOUT = 1'b0;
      smp();
      check("stall1_m0_ready", 32'(M0_HREADYOUT), 32'd0);
      check("stall1_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      check("stall1_hsel", 32'(S_HSEL), 32'd0);
      check("stall1_hwdata", S_HWDATA, 32'hA5A5_0001);
      cyc();
      smp();
      check("stall2_m0_ready", 32'(M0_HREADYOUT), 32'd0);
      check("stall2_m1_ready", 32'(M1_HREADYOUT), 32'd0);
      check("stall2_hsel", 32'(S_HSEL), 32'd0);
      cyc();
      m1(1'b0, 1'b0, 32'h0); S_HREADYOUT = 1'b1;
      smp();
      check("resume_hsel", 32'(S_HSEL), 32'd1);
      check("resume_haddr", S_HADDR, 32'hC0);
      check("resume_m0_ready", 32'(M0_HREADYOUT), 32'd1);
      check("resume_m1_ready", 32'(M1_HREADYOUT), 32'd0);
      cyc();
      smp();
      check("after_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      check("after_hsel", 32'(S_HSEL), 32'd0);
      check("after_cnt", 32'(CONFLICT_CNT), 32'd1);
      cyc();

      // Reset while M1 is parked discards it.
      m0(1'b1, 1'b1, 32'h300); m1(1'b1, 1'b0, 32'h400);
      smp();
      check("pre_rst_haddr", S_HADDR, 32'h300);
      cyc();
      m0(1'b0, 1'b0, 32'h0); m1(1'b0, 1'b0, 32'h0);
      HRESET = 1'b1; M0_HWDATA = 32'h5555_AAAA;
      smp();
      check("pre_rst_m1_ready", 32'(M1_HREADYOUT), 32'd0);
      cyc();
      HRESET = 1'b0;
      smp();
      check("post_rst_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      check("post_rst_m0_ready", 32'(M0_HREADYOUT), 32'd1);
      check("post_rst_hsel", 32'(S_HSEL), 32'd0);
      check("post_rst_hwdata", S_HWDATA, 32'h0);
      check("post_rst_cnt", 32'(CONFLICT_CNT), 32'd0);
      cyc();

      // Contention every cycle: counter climbs then sticks at all-ones.
      force_rdy = 1'b1;
      m0(1'b1, 1'b0, 32'h500); m1(1'b1, 1'b0, 32'h600);
      for (int i = 0; i < 65534; i++) cyc();
      smp();
      check("cnt_near_sat", 32'(CONFLICT_CNT), 32'h0000_FFFE);
      for (int i = 0; i < 7; i++) cyc();
      smp();
      check("cnt_saturated", 32'(CONFLICT_CNT), 32'h0000_FFFF);
      force_rdy = 1'b0;
      m0(1'b0, 1'b0, 32'h0); m1(1'b0, 1'b0, 32'h0);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_bram_arbiter.md
AHB_BRAM_ARBITER -- requirements
Module: ahb_bram_arbiter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the contention counter.
REQ-002 SHALL have port HCLK, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port HRESET, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have, for each x in {0,1}, ports Mx_HSEL / Mx_HTRANS[1:0] / Mx_HWRITE, inputs: master-x select, transfer type, write.
REQ-005 SHALL have, for each x in {0,1}, ports Mx_HADDR[31:0] / Mx_HSIZE[2:0] / Mx_HPROT[3:0] / Mx_HWDATA[31:0], inputs: master-x address, size, protection, write data.
REQ-006 SHALL have, for each x in {0,1}, port Mx_HREADY, input, 1: master-x bus ready.
REQ-007 SHALL have, for each x in {0,1}, ports Mx_HREADYOUT (1) / Mx_HRDATA (32) / Mx_HRESP (1), outputs: ready, read data and response to master x.
REQ-008 SHALL have ports S_HSEL (1) / S_HTRANS (2) / S_HWRITE (1), outputs: select, transfer type and write to the shared BRAM slave.
REQ-009 SHALL have ports S_HADDR (32) / S_HSIZE (3) / S_HPROT (4) / S_HWDATA (32), outputs: address, size, protection and write data to the shared BRAM slave.
REQ-010 SHALL have ports S_HREADYOUT (1) / S_HRDATA (32) / S_HRESP (1), inputs: ready, read data and response from the slave.
REQ-011 SHALL have port S_HREADY, output, 1: equals S_HREADYOUT.
REQ-012 SHALL have port CONFLICT_CNT, output, CNT_WIDTH: saturating count of same-cycle contention events.

Function
REQ-013 Live request x SHALL be Mx_HSEL & Mx_HTRANS[1] & Mx_HREADY.
REQ-014 Candidates per cycle SHALL be each live request plus each valid held request.
REQ-015 Arbitration SHALL occur only when S_HREADYOUT=1; the winner's address phase SHALL be driven combinationally that cycle with S_HSEL=1 and S_HTRANS=2'b10.
REQ-016 With no winner, S_HSEL and S_HTRANS SHALL be 0; the remaining S_* outputs SHALL be don't-care but stable.
REQ-017 A held request SHALL beat any live request.
REQ-018 With two equal-class candidates, the master not granted last SHALL win; last_grant SHALL update on every grant.
REQ-019 A live request not granted that cycle, whether from losing or from S_HREADYOUT=0, SHALL be captured into hold_x (addr, size, prot, write) with hold_valid_x set.
REQ-020 hold_valid_x SHALL clear in the cycle its request is issued.
REQ-021 Data-phase owner register SHALL have states NONE, M0, M1. It SHALL load the winner when issued with S_HREADYOUT=1, and SHALL go to NONE if S_HREADYOUT=1 with no issue.
REQ-022 S_HWDATA SHALL be the owner's Mx_HWDATA (0 when NONE). The master holds HWDATA stable while stalled.
REQ-023 Mx_HREADYOUT SHALL be 0 while hold_valid_x=1; S_HREADYOUT when owner=Mx; otherwise 1.
REQ-024 Mx_HRDATA SHALL be S_HRDATA for both masters.
REQ-025 Mx_HRESP SHALL be S_HRESP when owner=Mx, else 0.
REQ-026 Latency: a directly granted request SHALL add 0 cycles. A held request SHALL issue at the first cycle with S_HREADYOUT=1 after capture.
REQ-027 Each port SHALL have at most one held plus one data-phase transfer. A live request SHALL be accepted in the same cycle its previous data phase completes.
REQ-028 CONFLICT_CNT SHALL increment when two candidates exist in an arbitration cycle, and SHALL saturate at all-ones.

Reset
REQ-029 On HRESET=1 at a clock edge, the following SHALL take their reset values: hold_valid_0/1=0, owner=NONE, last_grant=M1 (so M0 wins first tie), CONFLICT_CNT=0.
REQ-030 Mx_HREADYOUT=1 and S_HSEL=0 SHALL result from the reset state; a reset mid-transfer SHALL discard held and in-flight transfers.

Structure
REQ-031 Package ahb_arb_pkg SHALL hold the HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10) and the owner enumeration.
REQ-032 Sub-module ahb_req_hold SHALL implement one port's capture register and valid flag, and SHALL be instantiated twice.

Verification
REQ-033 Scenario: M0 write 0x0000_0010 alone -> S_HADDR=0x10 same cycle, M0_HREADYOUT=1, BRAM write next cycle, CONFLICT_CNT=0.
REQ-034 Scenario: M0 read 0x20 and M1 read 0x40 same cycle after reset -> M0 issued, M1 held with M1_HREADYOUT=0. M1 issued next cycle; CONFLICT_CNT=1.
REQ-035 Scenario: repeat simultaneous requests 3 times -> grants alternate M1, M0, M1.
REQ-036 Scenario: S_HREADYOUT held 0 for 2 cycles during M0 data phase while M1 requests -> M1 captured, issued on the cycle S_HREADYOUT returns 1, M0_HREADYOUT follows S_HREADYOUT.
REQ-037 Scenario: HRESET pulsed while M1 held -> next cycle hold_valid_1=0, M1_HREADYOUT=1, owner=NONE.
REQ-038 Scenario: force 2^CNT_WIDTH+5 conflicts -> CONFLICT_CNT stays at 0xFFFF.
